// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: occupancy state encoding for pipe_stage_reg and
// the legacy control-field widths carried by the IF/ID .. MEM/WB stage payloads.
package pipe_pkg;

  typedef logic [1:0] pipe_state_t;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  localparam int CTRL_ALU_OP_W = 4;
  localparam int CTRL_MEM_OP_W = 3;
  localparam int CTRL_WB_SEL_W = 2;
  localparam int CTRL_W        = CTRL_ALU_OP_W + CTRL_MEM_OP_W + CTRL_WB_SEL_W;

endpackage

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with optional two-entry skid buffer, stall and flush.
// count_o is the raw occupancy state (EMPTY=0, ONE=1, TWO=2).
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W           = 32,
  parameter bit                SKID_EN          = 1'b1,
  parameter bit                FLUSH_OVER_STALL = 1'b0,
  parameter logic [DATA_W-1:0] RESET_VAL        = '0
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              in_ready_o,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  input  logic              out_ready_i,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic [1:0]        count_o
);

  // Handshake: a payload moves across a side only in a cycle where valid and
  // ready are both high at the rising edge and the effective stall is low.

  pipe_state_t       state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              stall_eff;
  logic              flush_eff;
  logic              in_xfer;
  logic              out_xfer;

  assign stall_eff = stall_i && !(flush_i && FLUSH_OVER_STALL);
  assign flush_eff = flush_i && !stall_eff;

  // With the skid entry, ready depends only on local state, never on out_ready_i.
  always_comb begin
    in_ready_o = 1'b0;
    if (SKID_EN) begin
      in_ready_o = (state_q != ST_TWO) && !stall_i && !flush_i;
    end else begin
      in_ready_o = ((state_q == ST_EMPTY) || out_ready_i) && !stall_i && !flush_i;
    end
  end

  assign out_valid_o = (state_q != ST_EMPTY) && !stall_i;
  assign out_data_o  = main_q;
  assign count_o     = state_q;

  assign in_xfer  = in_valid_i && in_ready_o && !stall_eff;
  assign out_xfer = out_valid_o && out_ready_i && !stall_eff && !flush_eff;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush_eff) begin
      state_d = ST_EMPTY;
      main_d  = RESET_VAL;
    end else if (!stall_eff) begin
      case (state_q)
        ST_EMPTY: begin
          if (in_xfer) begin
            state_d = ST_ONE;
            main_d  = in_data_i;
          end
        end
        ST_ONE: begin
          if (in_xfer && out_xfer) begin
            main_d = in_data_i;
          end else if (in_xfer) begin
            state_d = ST_TWO;
            skid_d  = in_data_i;
          end else if (out_xfer) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (out_xfer) begin
            state_d = ST_ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_EMPTY;
      main_q  <= RESET_VAL;
      skid_q  <= RESET_VAL;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: vector table on the default-priority skid
// stage, plus hand sequences for reset, flush-over-stall and the no-skid variant.
module tb_pipe_stage_reg;

  localparam logic [7:0] RV0 = 8'hE5;

  typedef struct {
    logic       stall;
    logic       flush;
    logic       iv;
    logic [7:0] d;
    logic       ordy;
    logic [1:0] cnt;
    logic       ov;
    logic [7:0] od;
    logic       ir;
  } vec_t;

  int checks = 0;
  int errors = 0;

  logic clk = 1'b0;
  logic rst_n;

  logic       iv0, ir0, ov0, or0, st0, fl0;
  logic [7:0] id0, od0;
  logic [1:0] cnt0;
  logic       iv1, ir1, ov1, or1, st1, fl1;
  logic [7:0] id1, od1;
  logic [1:0] cnt1;
  logic       iv2, ir2, ov2, or2, st2, fl2;
  logic [7:0] id2, od2;
  logic [1:0] cnt2;

  vec_t       vecs[$];
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(8), .SKID_EN(1'b1), .FLUSH_OVER_STALL(1'b0), .RESET_VAL(RV0)) u0 (
    .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(iv0), .in_data_i(id0), .in_ready_o(ir0),
    .out_valid_o(ov0), .out_data_o(od0), .out_ready_i(or0), .stall_i(st0), .flush_i(fl0),
    .count_o(cnt0));

  pipe_stage_reg #(.DATA_W(8), .SKID_EN(1'b1), .FLUSH_OVER_STALL(1'b1)) u1 (
    .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(iv1), .in_data_i(id1), .in_ready_o(ir1),
    .out_valid_o(ov1), .out_data_o(od1), .out_ready_i(or1), .stall_i(st1), .flush_i(fl1),
    .count_o(cnt1));

  pipe_stage_reg #(.DATA_W(8), .SKID_EN(1'b0), .FLUSH_OVER_STALL(1'b0)) u2 (
    .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(iv2), .in_data_i(id2), .in_ready_o(ir2),
    .out_valid_o(ov2), .out_data_o(od2), .out_ready_i(or2), .stall_i(st2), .flush_i(fl2),
    .count_o(cnt2));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add_vec(input logic stall, input logic flush, input logic iv, input logic [7:0] d,
                         input logic ordy, input logic [1:0] cnt, input logic ov,
                         input logic [7:0] od, input logic ir);
    vec_t v;
    v.stall = stall; v.flush = flush; v.iv = iv; v.d = d; v.ordy = ordy;
    v.cnt = cnt; v.ov = ov; v.od = od; v.ir = ir;
    vecs.push_back(v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // stall flush iv data ordy | count ov out_data in_ready  (outputs seen before the edge)
    add_vec(0, 0, 1, 8'h11, 1, 2'd0, 0, RV0,   1); // streaming
    add_vec(0, 0, 1, 8'h22, 1, 2'd1, 1, 8'h11, 1);
    add_vec(0, 0, 1, 8'h33, 1, 2'd1, 1, 8'h22, 1);
    add_vec(0, 0, 0, 8'h00, 1, 2'd1, 1, 8'h33, 1);
    add_vec(0, 0, 0, 8'h00, 1, 2'd0, 0, 8'h33, 1);
    add_vec(0, 0, 1, 8'hA0, 0, 2'd0, 0, 8'h33, 1); // backpressure
    add_vec(0, 0, 1, 8'hB0, 0, 2'd1, 1, 8'hA0, 1);
    add_vec(0, 0, 1, 8'hC0, 0, 2'd2, 1, 8'hA0, 0);
    add_vec(0, 0, 1, 8'hC0, 1, 2'd2, 1, 8'hA0, 0);
    add_vec(0, 0, 1, 8'hC0, 1, 2'd1, 1, 8'hB0, 1);
    add_vec(0, 0, 0, 8'h00, 0, 2'd1, 1, 8'hC0, 1);
    add_vec(0, 0, 0, 8'h00, 1, 2'd1, 1, 8'hC0, 1);
    add_vec(0, 0, 1, 8'h55, 0, 2'd0, 0, 8'hC0, 1); // flush
    add_vec(0, 0, 0, 8'h00, 0, 2'd1, 1, 8'h55, 1);
    add_vec(0, 1, 1, 8'h66, 1, 2'd1, 1, 8'h55, 0);
    add_vec(0, 0, 0, 8'h00, 0, 2'd0, 0, RV0,   1);
    add_vec(0, 0, 1, 8'h77, 0, 2'd0, 0, RV0,   1); // stall beats flush
    add_vec(1, 1, 1, 8'h88, 1, 2'd1, 0, 8'h77, 0);
    add_vec(1, 0, 0, 8'h00, 1, 2'd1, 0, 8'h77, 0);
    add_vec(0, 0, 0, 8'h00, 0, 2'd1, 1, 8'h77, 1);
    add_vec(0, 0, 1, 8'h90, 0, 2'd1, 1, 8'h77, 1); // stall and no overwrite in TWO
    add_vec(1, 0, 1, 8'h91, 1, 2'd2, 0, 8'h77, 0);
    add_vec(0, 0, 1, 8'h92, 0, 2'd2, 1, 8'h77, 0);
    add_vec(0, 0, 0, 8'h00, 1, 2'd2, 1, 8'h77, 0);
    add_vec(0, 0, 0, 8'h00, 1, 2'd1, 1, 8'h90, 1);
    add_vec(0, 0, 0, 8'h00, 1, 2'd0, 0, 8'h90, 1);

    rst_n = 1'b0;
    iv0 = 0; id0 = 0; or0 = 0; st0 = 0; fl0 = 0;
    iv1 = 0; id1 = 0; or1 = 0; st1 = 0; fl1 = 0;
    iv2 = 0; id2 = 0; or2 = 0; st2 = 0; fl2 = 0;
    #12;
    check("rst count", 32'(cnt0), 32'd0);
    check("rst out_valid", 32'(ov0), 32'd0);
    check("rst out_data", 32'(od0), 32'(RV0));
    check("rst in_ready", 32'(ir0), 32'd1);
    check("rst u1 out_data", 32'(od1), 32'd0);
    check("rst u2 in_ready", 32'(ir2), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    foreach (vecs[i]) begin
      st0 = vecs[i].stall; fl0 = vecs[i].flush; iv0 = vecs[i].iv;
      id0 = vecs[i].d;     or0 = vecs[i].ordy;
      @(negedge clk);
      check($sformatf("v%0d count", i), 32'(cnt0), 32'(vecs[i].cnt));
      check($sformatf("v%0d out_valid", i), 32'(ov0), 32'(vecs[i].ov));
      check($sformatf("v%0d out_data", i), 32'(od0), 32'(vecs[i].od));
      check($sformatf("v%0d in_ready", i), 32'(ir0), 32'(vecs[i].ir));
      tick();
    end

    // Reset dropped between edges while two payloads are held.
    st0 = 0; fl0 = 0; or0 = 0;
    iv0 = 1; id0 = 8'h3C; tick();
    iv0 = 1; id0 = 8'h4C; tick();
    iv0 = 0;
    check("pre-reset count", 32'(cnt0), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    check("async rst count", 32'(cnt0), 32'd0);
    check("async rst out_valid", 32'(ov0), 32'd0);
    check("async rst out_data", 32'(od0), 32'(RV0));
    check("async rst in_ready", 32'(ir0), 32'd1);
    st0 = 1; #1;
    check("rst in_ready stalled", 32'(ir0), 32'd0);
    st0 = 0;
    @(negedge clk);
    rst_n = 1'b1;
    iv0 = 1; id0 = 8'h01;
    #1;
    check("post-rst in_ready", 32'(ir0), 32'd1);
    tick();
    iv0 = 0;
    check("post-rst count", 32'(cnt0), 32'd1);
    check("post-rst out_data", 32'(od0), 32'h01);
    check("post-rst out_valid", 32'(ov0), 32'd1);

    // Flush beats stall.
    iv1 = 1; id1 = 8'h77; tick();
    iv1 = 1; id1 = 8'h78; st1 = 1; fl1 = 1;
    @(negedge clk);
    check("fos in_ready", 32'(ir1), 32'd0);
    check("fos out_valid", 32'(ov1), 32'd0);
    tick();
    iv1 = 0; st1 = 0; fl1 = 0;
    check("fos count", 32'(cnt1), 32'd0);
    check("fos out_valid after", 32'(ov1), 32'd0);
    check("fos out_data", 32'(od1), 32'd0);
    iv1 = 1; id1 = 8'h12; tick();
    iv1 = 0; st1 = 1; or1 = 1; tick();
    st1 = 0;
    check("fos stall holds count", 32'(cnt1), 32'd1);
    check("fos stall holds data", 32'(od1), 32'h12);

    // No-skid variant: ready follows out_ready_i once occupied.
    iv2 = 1; id2 = 8'h5A; or2 = 0; tick();
    id2 = 8'h6B;
    #1;
    check("noskid ready low", 32'(ir2), 32'd0);
    tick();
    check("noskid held count", 32'(cnt2), 32'd1);
    check("noskid held data", 32'(od2), 32'h5A);
    or2 = 1;
    #1;
    check("noskid ready high", 32'(ir2), 32'd1);
    tick();
    check("noskid replace data", 32'(od2), 32'h6B);
    check("noskid replace count", 32'(cnt2), 32'd1);
    iv2 = 0; tick();
    check("noskid drained", 32'(cnt2), 32'd0);

    // No-skid streaming against an expected queue.
    for (int k = 0; k < 6; k++) begin
      iv2 = (k < 4);
      id2 = 8'h20 + 8'(k * 17);
      or2 = 1;
      @(negedge clk);
      if (ov2 && or2) begin
        if (exp_q.size() == 0) begin
          check("noskid unexpected output", 32'(od2), 32'hFFFF_FFFF);
        end else begin
          check($sformatf("noskid stream %0d", k), 32'(od2), 32'(exp_q.pop_front()));
        end
      end
      if (iv2 && ir2) exp_q.push_back(id2);
      tick();
    end
    check("noskid stream leftover", 32'(exp_q.size()), 32'd0);
    check("noskid stream count", 32'(cnt2), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
